// File: rtl/axis_width_converter.sv
// -----------------------------------------------------------------------------
// axis_width_converter
//
// AXI4-Stream lane-width converter. Input beats carry S_KEEP_WIDTH lanes and
// output beats carry M_KEEP_WIDTH lanes, each lane T_DATA_WIDTH bits wide.
// Kept input lanes are compacted into a circular lane buffer of
// DEPTH = DEPTH_MULT * max(S_KEEP_WIDTH, M_KEEP_WIDTH) slots. Each slot also
// holds a packet-end flag. Output beats are drawn from the buffer into a
// registered output stage. An output beat never spans two packets.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   s_data_i     input lanes, lane i at bits [i*T_DATA_WIDTH +: T_DATA_WIDTH]
//   s_keep_i     per-lane keep for the input beat
//   s_tlast_i    input beat ends a packet
//   s_valid_i    input beat valid
//   s_ready_o    room for a full input beat (depends on registered state only)
//   m_data_o     output lanes, low-aligned, unused lanes driven to zero
//   m_keep_o     contiguous low-aligned keep for the output beat
//   m_tlast_o    output beat ends a packet
//   m_valid_o    output beat valid (registered)
//   m_ready_i    downstream accepts the output beat
//   occupancy_o  lanes currently held in the buffer (output register excluded)
// -----------------------------------------------------------------------------
module axis_width_converter #(
   parameter int T_DATA_WIDTH = 8,
   parameter int S_KEEP_WIDTH = 4,
   parameter int M_KEEP_WIDTH = 2,
   parameter int DEPTH_MULT   = 4,
   localparam int DEPTH = DEPTH_MULT *
                          ((S_KEEP_WIDTH > M_KEEP_WIDTH) ? S_KEEP_WIDTH : M_KEEP_WIDTH),
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0] s_data_i,
   input  logic [S_KEEP_WIDTH-1:0]              s_keep_i,
   input  logic                                 s_tlast_i,
   input  logic                                 s_valid_i,
   output logic                                 s_ready_o,
   output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] m_data_o,
   output logic [M_KEEP_WIDTH-1:0]              m_keep_o,
   output logic                                 m_tlast_o,
   output logic                                 m_valid_o,
   input  logic                                 m_ready_i,
   output logic [PW-1:0]                        occupancy_o
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [T_DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]        last_q;
   logic [PW-1:0]           wr_ptr_q;
   logic [PW-1:0]           rd_ptr_q;
   logic [PW-1:0]           occ_q;
   // Empty packets (null last with nothing buffered to attach to) still owed
   // to the output as keep=0/tlast=1 beats. Saturates at its maximum.
   logic [PW-1:0]           null_cnt_q;

   assign occupancy_o = occ_q;
   assign s_ready_o   = (occ_q <= PW'(DEPTH - S_KEEP_WIDTH));

   logic accept;
   assign accept = s_valid_i && s_ready_o;

   // ---------------------------------------------------------------------------
   // Write side: compaction of kept lanes
   // ---------------------------------------------------------------------------
   logic [PW-1:0]           n_wr;
   logic [PW-1:0]           wr_off [S_KEEP_WIDTH];
   logic [AW-1:0]           wr_idx [S_KEEP_WIDTH];
   logic [S_KEEP_WIDTH-1:0] lane_last;
   logic [AW-1:0]           prev_idx;

   // NOTE: combinational blocks use blocking '=' so the running lane count is
   // seen by the next loop iteration; sequential blocks below use '<=' only.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      n_wr      = '0;
      lane_last = '0;
      for (int i = 0; i < S_KEEP_WIDTH; i++) begin
         wr_off[i] = n_wr;
         wr_idx[i] = wr_ptr_q[AW-1:0] + n_wr[AW-1:0];
         n_wr      = n_wr + PW'(s_keep_i[i]);
      end
      // Only the highest kept lane of a last beat carries the packet end.
      for (int i = 0; i < S_KEEP_WIDTH; i++) begin
         lane_last[i] = s_keep_i[i] && s_tlast_i && (wr_off[i] == n_wr - PW'(1));
      end
      prev_idx = wr_ptr_q[AW-1:0] - AW'(1);
   end

   // ---------------------------------------------------------------------------
   // Read side: how many slots the next output beat takes
   // ---------------------------------------------------------------------------
   logic [PW-1:0] n_take;
   logic          found;
   logic [AW-1:0] scan_idx;

   always_comb begin
      n_take   = '0;
      found    = 1'b0;
      scan_idx = '0;
      // Stop at the first packet end within reach so a beat never crosses it.
      for (int j = 0; j < M_KEEP_WIDTH; j++) begin
         scan_idx = rd_ptr_q[AW-1:0] + AW'(j);
         if (!found && (PW'(j) < occ_q) && last_q[scan_idx]) begin
            found  = 1'b1;
            n_take = PW'(j + 1);
         end
      end
      if (!found && (occ_q >= PW'(M_KEEP_WIDTH))) begin
         n_take = PW'(M_KEEP_WIDTH);
      end
   end

   logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] rd_data;
   logic [M_KEEP_WIDTH-1:0]              rd_keep;
   logic                                 rd_last;
   logic [AW-1:0]                        rd_idx;

   always_comb begin
      rd_data = '0;
      rd_keep = '0;
      rd_last = 1'b0;
      rd_idx  = '0;
      for (int j = 0; j < M_KEEP_WIDTH; j++) begin
         rd_idx = rd_ptr_q[AW-1:0] + AW'(j);
         if (PW'(j) < n_take) begin
            rd_data[j*T_DATA_WIDTH +: T_DATA_WIDTH] = mem[rd_idx];
            rd_keep[j] = 1'b1;
            rd_last    = last_q[rd_idx];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register load decision
   // ---------------------------------------------------------------------------
   logic          out_free;
   logic          load_null;
   logic          load_data;
   logic [PW-1:0] n_rd;
   logic [PW-1:0] n_wr_acc;
   logic [PW-1:0] occ_after_rd;
   logic          null_last;
   logic          null_to_slot;
   logic          null_to_beat;

   assign out_free  = !m_valid_o || m_ready_i;
   // A pending empty packet predates everything now buffered, so it goes first.
   assign load_null = out_free && (null_cnt_q != '0);
   assign load_data = out_free && !load_null && (n_take != '0);
   assign n_rd      = load_data ? n_take : '0;
   assign n_wr_acc  = accept ? n_wr : '0;

   // A keep=0 last beat marks the newest buffered lane if one survives this
   // edge's read; otherwise it becomes an empty output beat of its own.
   assign occ_after_rd = occ_q - n_rd;
   assign null_last    = accept && (s_keep_i == '0) && s_tlast_i;
   assign null_to_slot = null_last && (occ_after_rd != '0);
   assign null_to_beat = null_last && (occ_after_rd == '0);

   // ---------------------------------------------------------------------------
   // Lane storage
   // ---------------------------------------------------------------------------
   // NOTE: the data array is deliberately not reset; the pointers and
   // occupancy define which slots are valid, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            if (s_keep_i[i]) begin
               mem[wr_idx[i]] <= s_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control state and output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         null_cnt_q <= '0;
         m_data_o   <= '0;
         m_keep_o   <= '0;
         m_tlast_o  <= 1'b0;
         m_valid_o  <= 1'b0;
      end else begin
         if (accept) begin
            for (int i = 0; i < S_KEEP_WIDTH; i++) begin
               if (s_keep_i[i]) begin
                  last_q[wr_idx[i]] <= lane_last[i];
               end
            end
         end
         if (null_to_slot) begin
            last_q[prev_idx] <= 1'b1;
         end

         wr_ptr_q <= wr_ptr_q + n_wr_acc;
         rd_ptr_q <= rd_ptr_q + n_rd;
         occ_q    <= occ_q + n_wr_acc - n_rd;

         if (null_to_beat && !load_null) begin
            if (null_cnt_q != '1) begin
               null_cnt_q <= null_cnt_q + PW'(1);
            end
         end else if (load_null && !null_to_beat) begin
            null_cnt_q <= null_cnt_q - PW'(1);
         end

         if (load_null) begin
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_tlast_o <= 1'b1;
            m_valid_o <= 1'b1;
         end else if (load_data) begin
            m_data_o  <= rd_data;
            m_keep_o  <= rd_keep;
            m_tlast_o <= rd_last;
            m_valid_o <= 1'b1;
         end else if (out_free) begin
            m_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_width_converter.sv
// -----------------------------------------------------------------------------
// tb_axis_width_converter
//
// Directed bench for axis_width_converter. Instance "a" uses the default
// geometry (4 lanes in, 2 lanes out, depth 16); instance "b" uses 2 lanes in,
// 4 lanes out. Single-beat packets run from a vector table; multi-cycle corner
// cases (latency, partial hold, backpressure, reset mid-packet) are written
// out by hand.
// -----------------------------------------------------------------------------
module tb_axis_width_converter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Instance a: S=4, M=2
   logic [31:0] a_s_data;
   logic [3:0]  a_s_keep;
   logic        a_s_tlast, a_s_valid, a_s_ready;
   logic [15:0] a_m_data;
   logic [1:0]  a_m_keep;
   logic        a_m_tlast, a_m_valid, a_m_ready;
   logic [4:0]  a_occ;

   // Instance b: S=2, M=4
   logic [15:0] b_s_data;
   logic [1:0]  b_s_keep;
   logic        b_s_tlast, b_s_valid, b_s_ready;
   logic [31:0] b_m_data;
   logic [3:0]  b_m_keep;
   logic        b_m_tlast, b_m_valid, b_m_ready;
   logic [4:0]  b_occ;

   axis_width_converter u_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_data_i    (a_s_data),
      .s_keep_i    (a_s_keep),
      .s_tlast_i   (a_s_tlast),
      .s_valid_i   (a_s_valid),
      .s_ready_o   (a_s_ready),
      .m_data_o    (a_m_data),
      .m_keep_o    (a_m_keep),
      .m_tlast_o   (a_m_tlast),
      .m_valid_o   (a_m_valid),
      .m_ready_i   (a_m_ready),
      .occupancy_o (a_occ)
   );

   axis_width_converter #(
      .T_DATA_WIDTH (8),
      .S_KEEP_WIDTH (2),
      .M_KEEP_WIDTH (4),
      .DEPTH_MULT   (4)
   ) u_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_data_i    (b_s_data),
      .s_keep_i    (b_s_keep),
      .s_tlast_i   (b_s_tlast),
      .s_valid_i   (b_s_valid),
      .s_ready_o   (b_s_ready),
      .m_data_o    (b_m_data),
      .m_keep_o    (b_m_keep),
      .m_tlast_o   (b_m_tlast),
      .m_valid_o   (b_m_valid),
      .m_ready_i   (b_m_ready),
      .occupancy_o (b_occ)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t = 0;
      a_s_data  = d;
      a_s_keep  = k;
      a_s_tlast = l;
      a_s_valid = 1'b1;
      while (!a_s_ready && t < 50) begin
         step();
         t++;
      end
      check("a send ready", a_s_ready, 1);
      step();
      a_s_valid = 1'b0;
   endtask

   task automatic expect_a(input string name, input logic [15:0] d, input logic [1:0] k,
                           input logic l);
      int t = 0;
      a_m_ready = 1'b1;
      while (!a_m_valid && t < 50) begin
         step();
         t++;
      end
      check({name, " valid"}, a_m_valid, 1);
      check({name, " data"},  a_m_data,  d);
      check({name, " keep"},  a_m_keep,  k);
      check({name, " last"},  a_m_tlast, l);
      step();
   endtask

   task automatic send_b(input logic [15:0] d, input logic [1:0] k, input logic l);
      int t = 0;
      b_s_data  = d;
      b_s_keep  = k;
      b_s_tlast = l;
      b_s_valid = 1'b1;
      while (!b_s_ready && t < 50) begin
         step();
         t++;
      end
      check("b send ready", b_s_ready, 1);
      step();
      b_s_valid = 1'b0;
   endtask

   task automatic expect_b(input string name, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
      int t = 0;
      b_m_ready = 1'b1;
      while (!b_m_valid && t < 50) begin
         step();
         t++;
      end
      check({name, " valid"}, b_m_valid, 1);
      check({name, " data"},  b_m_data,  d);
      check({name, " keep"},  b_m_keep,  k);
      check({name, " last"},  b_m_tlast, l);
      step();
   endtask

   // One input beat and up to two expected output beats.
   // Beat b: data ed[16*b +: 16], keep ek[2*b +: 2], last el[b].
   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          nb;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic [1:0]  el;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n_acc;
      logic acc_now;
      logic [7:0] lo;

      vecs[0] = '{data: 32'h0302_0100, keep: 4'b1111, last: 1'b1, nb: 2,
                  ed: 32'h0302_0100, ek: 4'b1111, el: 2'b10};
      vecs[1] = '{data: 32'hFFA2_EEA0, keep: 4'b0101, last: 1'b1, nb: 1,
                  ed: 32'h0000_A2A0, ek: 4'b0011, el: 2'b01};
      vecs[2] = '{data: 32'hFF12_1110, keep: 4'b0111, last: 1'b1, nb: 2,
                  ed: 32'h0012_1110, ek: 4'b0111, el: 2'b10};
      vecs[3] = '{data: 32'hDEAD_BEEF, keep: 4'b0000, last: 1'b1, nb: 1,
                  ed: 32'h0000_0000, ek: 4'b0000, el: 2'b01};
      vecs[4] = '{data: 32'h7766_5544, keep: 4'b1000, last: 1'b1, nb: 1,
                  ed: 32'h0000_0077, ek: 4'b0001, el: 2'b01};
      vecs[5] = '{data: 32'h9988_7766, keep: 4'b0110, last: 1'b1, nb: 1,
                  ed: 32'h0000_8877, ek: 4'b0011, el: 2'b01};
      vecs[6] = '{data: 32'h4433_2211, keep: 4'b1010, last: 1'b1, nb: 1,
                  ed: 32'h0000_4422, ek: 4'b0011, el: 2'b01};

      rst_n     = 1'b0;
      a_s_data  = '0; a_s_keep = '0; a_s_tlast = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
      b_s_data  = '0; b_s_keep = '0; b_s_tlast = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0;
      step();
      step();

      // Reset state
      check("a rst occ",    a_occ,     0);
      check("a rst ready",  a_s_ready, 1);
      check("a rst valid",  a_m_valid, 0);
      check("a rst keep",   a_m_keep,  0);
      check("a rst data",   a_m_data,  0);
      check("a rst last",   a_m_tlast, 0);
      check("b rst ready",  b_s_ready, 1);
      check("b rst valid",  b_m_valid, 0);
      rst_n = 1'b1;
      step();

      // Full beat: first-output latency and back-to-back output beats
      a_m_ready = 1'b1;
      a_s_data  = 32'h0302_0100;
      a_s_keep  = 4'b1111;
      a_s_tlast = 1'b1;
      a_s_valid = 1'b1;
      step();
      a_s_valid = 1'b0;
      check("lat valid k",   a_m_valid, 0);
      check("lat occ k",     a_occ,     4);
      step();
      check("b2b0 valid",    a_m_valid, 1);
      check("b2b0 data",     a_m_data,  16'h0100);
      check("b2b0 keep",     a_m_keep,  2'b11);
      check("b2b0 last",     a_m_tlast, 0);
      step();
      check("b2b1 valid",    a_m_valid, 1);
      check("b2b1 data",     a_m_data,  16'h0302);
      check("b2b1 keep",     a_m_keep,  2'b11);
      check("b2b1 last",     a_m_tlast, 1);
      step();
      check("b2b idle valid", a_m_valid, 0);
      check("b2b idle occ",   a_occ,     0);

      // Single-beat packets from the table
      for (int i = 0; i < 7; i++) begin
         send_a(vecs[i].data, vecs[i].keep, vecs[i].last);
         for (int b = 0; b < vecs[i].nb; b++) begin
            expect_a($sformatf("vec%0d beat%0d", i, b), vecs[i].ed[16*b +: 16],
                     vecs[i].ek[2*b +: 2], vecs[i].el[b]);
         end
         check($sformatf("vec%0d drained valid", i), a_m_valid, 0);
         check($sformatf("vec%0d drained occ", i),   a_occ,     0);
      end

      // Partial non-last data is held until the packet completes
      send_a(32'hFFFF_FF5A, 4'b0001, 1'b0);
      repeat (10) step();
      check("hold occ",   a_occ,     1);
      check("hold valid", a_m_valid, 0);
      send_a(32'h0000_005B, 4'b0001, 1'b1);
      expect_a("hold out", 16'h5B5A, 2'b11, 1'b1);

      // Null last attaches to the newest buffered lane
      send_a(32'h0000_0061, 4'b0001, 1'b0);
      send_a(32'h0000_0000, 4'b0000, 1'b1);
      expect_a("nullslot", 16'h0061, 2'b01, 1'b1);
      check("nullslot drained valid", a_m_valid, 0);

      // Backpressure: full beats offered while the output is stalled
      a_m_ready = 1'b0;
      a_s_keep  = 4'b1111;
      a_s_valid = 1'b1;
      n_acc     = 0;
      for (int c = 0; c < 8; c++) begin
         for (int l = 0; l < 4; l++) begin
            a_s_data[8*l +: 8] = 8'(64 + 4*n_acc + l);
         end
         a_s_tlast = (n_acc == 3);
         acc_now   = a_s_ready;
         step();
         if (acc_now) n_acc++;
      end
      a_s_valid = 1'b0;
      check("bp accepted", n_acc,     4);
      check("bp occ",      a_occ,     14);
      check("bp ready",    a_s_ready, 0);
      check("bp valid",    a_m_valid, 1);
      check("bp data",     a_m_data,  16'h4140);
      check("bp keep",     a_m_keep,  2'b11);
      check("bp last",     a_m_tlast, 0);
      repeat (3) step();
      check("bp stable valid", a_m_valid, 1);
      check("bp stable data",  a_m_data,  16'h4140);
      check("bp stable occ",   a_occ,     14);
      for (int b = 0; b < 8; b++) begin
         lo = 8'(64 + 2*b);
         expect_a($sformatf("bp out%0d", b), {lo + 8'd1, lo}, 2'b11, (b == 7));
      end
      check("bp drained valid", a_m_valid, 0);
      check("bp drained occ",   a_occ,     0);

      // Instance b: two narrow beats merge into one wide beat
      b_m_ready = 1'b1;
      send_b(16'h0100, 2'b11, 1'b0);
      send_b(16'h0302, 2'b11, 1'b1);
      expect_b("b merge", 32'h0302_0100, 4'b1111, 1'b1);
      check("b merge drained", b_m_valid, 0);

      // Instance b: reset with a stalled output beat and a partial packet
      b_m_ready = 1'b0;
      send_b(16'h0504, 2'b11, 1'b0);
      send_b(16'h0706, 2'b11, 1'b0);
      send_b(16'h0908, 2'b11, 1'b0);
      step();
      check("b pre-rst valid", b_m_valid, 1);
      check("b pre-rst data",  b_m_data,  32'h0706_0504);
      check("b pre-rst occ",   b_occ,     2);
      rst_n = 1'b0;
      step();
      check("b mid-rst occ",   b_occ,     0);
      check("b mid-rst ready", b_s_ready, 1);
      check("b mid-rst valid", b_m_valid, 0);
      check("b mid-rst keep",  b_m_keep,  0);
      check("b mid-rst data",  b_m_data,  0);
      check("b mid-rst last",  b_m_tlast, 0);
      rst_n     = 1'b1;
      b_m_ready = 1'b1;
      step();
      send_b(16'h2120, 2'b11, 1'b0);
      send_b(16'h2322, 2'b11, 1'b1);
      expect_b("b post-rst", 32'h2322_2120, 4'b1111, 1'b1);
      check("b post-rst drained valid", b_m_valid, 0);
      check("b post-rst drained occ",   b_occ,     0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_width_converter.md
AXIS_WIDTH_CONVERTER -- requirements
Module: axis_width_converter

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, lane data width in bits.
REQ-002 SHALL have parameter S_KEEP_WIDTH, default 4, input lanes per beat (>=1).
REQ-003 SHALL have parameter M_KEEP_WIDTH, default 2, output lanes per beat (>=1).
REQ-004 SHALL have parameter DEPTH_MULT, default 4, buffer depth = DEPTH_MULT*max(S_KEEP_WIDTH,M_KEEP_WIDTH) lanes (power of two).
REQ-005 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have ports s_data_i [S_KEEP_WIDTH] x T_DATA_WIDTH, s_keep_i S_KEEP_WIDTH, s_tlast_i 1, s_valid_i 1 (inputs) and s_ready_o 1 (output): slave AXI4-Stream.
REQ-008 SHALL have ports m_data_o [M_KEEP_WIDTH] x T_DATA_WIDTH, m_keep_o M_KEEP_WIDTH, m_tlast_o 1, m_valid_o 1 (outputs) and m_ready_i 1 (input): master AXI4-Stream.
REQ-009 SHALL have port occupancy_o, output, $clog2(DEPTH)+1, lanes stored in buffer (excludes output register).

Function
REQ-010 SHALL accept an input beat on the edge where s_valid_i && s_ready_o.
REQ-011 SHALL compact kept lanes: lanes with s_keep_i[i]=1 written to consecutive buffer slots in ascending i; unkept lanes discarded.
REQ-012 SHALL store a per-slot last flag, set only on the highest kept lane of a beat with s_tlast_i=1.
REQ-013 SHALL, for an accepted beat with s_keep_i=0 and s_tlast_i=1, set last flag on the most recently written slot if still buffered; otherwise emit one beat with m_keep_o=0, m_tlast_o=1.
REQ-014 SHALL drive s_ready_o=1 iff free slots (DEPTH - occupancy) >= S_KEEP_WIDTH, computed from registered state only (no combinational path from s_valid_i or m_ready_i).
REQ-015 SHALL hold occupancy and read/write pointers in $clog2(DEPTH)+1-bit arithmetic; pointers wrap modulo DEPTH.
REQ-016 SHALL register all m_* outputs; loading the output register allowed when !m_valid_o or (m_valid_o && m_ready_i) on the same edge.
REQ-017 SHALL load an output beat only when occupancy >= M_KEEP_WIDTH or a last flag lies within the first M_KEEP_WIDTH buffered slots.
REQ-018 SHALL take slots up to and including the first last-flagged slot, max M_KEEP_WIDTH; a beat never spans two packets.
REQ-019 SHALL place taken slots in lanes 0.. upward, m_keep_o low-aligned contiguous ones, unused m_data_o lanes = 0, m_tlast_o = last flag of final taken slot.
REQ-020 SHALL hold m_data_o, m_keep_o, m_tlast_o, m_valid_o stable while m_valid_o && !m_ready_i.
REQ-021 SHALL deassert m_valid_o after a handshake when no beat is loadable; SHALL sustain one output beat per cycle when loadable.
REQ-022 SHALL give latency: beat accepted on edge k -> m_valid_o high after edge k+1 at earliest (output register empty).
REQ-023 SHALL update occupancy by written minus read slots when write and read occur on the same edge.
REQ-024 SHALL hold partial non-last data (< M_KEEP_WIDTH slots, no last flag) indefinitely; no timeout flush.
REQ-025 SHALL never drop, duplicate or reorder kept lanes.

Reset
REQ-026 SHALL, while rst_n=0 at an edge, clear pointers, occupancy_o=0, last flags=0, m_valid_o=0, m_tlast_o=0, m_keep_o=0, m_data_o=0, s_ready_o=1 after that edge (S_KEEP_WIDTH <= DEPTH).
REQ-027 SHALL discard any partial packet on reset mid-operation; first packet after reset is processed unaffected.

Verification (defaults S=4, M=2, T=8, DEPTH=16)
REQ-028 SHALL verify full beat: data {3:0x03,2:0x02,1:0x01,0:0x00}, keep 1111, tlast 1, m_ready 1 -> beats {0x01,0x00} keep 11 tlast 0, then {0x03,0x02} keep 11 tlast 1, back-to-back.
REQ-029 SHALL verify sparse keep: lane0=0xA0, lane2=0xA2, keep 0101, tlast 1 -> one beat {1:0xA2,0:0xA0} keep 11 tlast 1.
REQ-030 SHALL verify odd tail: keep 0111 tlast 1, data 0x10,0x11,0x12 -> {0x11,0x10} keep 11 tlast 0; {0x00,0x12} keep 01 tlast 1.
REQ-031 SHALL verify backpressure: m_ready 0, s_valid 1 with full beats -> exactly 4 beats accepted, occupancy_o=14, s_ready_o=0, m_* stable; release m_ready -> all 16 lanes out in order.
REQ-032 SHALL verify null-last: keep 0000 tlast 1 on empty buffer -> one beat m_keep_o=00, m_tlast_o=1.
REQ-033 SHALL verify S=2, M=4: two beats keep 11 (0x0,0x1 then 0x2,0x3 tlast 1) -> one beat {0x3,0x2,0x1,0x0} keep 1111 tlast 1; assert rst_n=0 mid-packet -> all outputs at reset values next cycle.
